bps_seq: RTL and testbench
==========================

Name: bps_seq

Overview:
- Opcode sequencer for one bps tile.
- Replaces the hand-driven opcode sequence: LOAD once, then N iterations of DOWN / STORE_DOWN / UP / STORE_UP.
- Issues each opcode as a one-cycle pulse and waits for bps stall to clear before the next.
- Sits between the host control/CSR logic and the bps opcode/addr_base inputs.

Parameters:
- ITER_W, 16, width of the iteration count and counter.
- GUARD, 1, cycles after an opcode pulse during which bps_stall is ignored (covers the stall-rise latency); legal range 1..3.
- TIMEOUT_W, 20, watchdog counter width (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- abort  in  1  stop after the current opcode completes.
- iterations  in  ITER_W  number of passes; sampled on start.
- addr_base_in  in  64  base address; sampled on start.
- store_last_only  in  1  sampled on start; 1 = skip STORE_DOWN/STORE_UP except on the final iteration.
- bps_opcode  out  3  to bps: 0 IDLE, 1 LOAD, 2 DOWN, 3 UP, 4 STORE_DOWN, 5 STORE_UP.
- bps_addr_base  out  64  to bps; held constant throughout a run.
- bps_stall  in  1  from bps; high while bps is executing.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at the end of a run.
- iter_count  out  ITER_W  completed iterations in the current/last run.
- error  out  1  watchdog flag (optional feature; tied 0 without it).

Behaviour:
- Reset values: bps_opcode=0, bps_addr_base=0, busy=0, done=0, iter_count=0, error=0; FSM=IDLE.
- Reset applies mid-run: FSM returns to IDLE immediately and bps_opcode is forced to 0 on that edge.
- FSM states: IDLE, ISSUE, GUARD, WAIT, NEXT, FIN.
- IDLE:
  - On start, latch iterations, addr_base_in and store_last_only; set busy=1, iter_count=0.
  - If iterations==0, go to FIN (no opcodes issued, done pulses one cycle later). Otherwise set op=LOAD and go to ISSUE.
- ISSUE:
  - Only when bps_stall==0: drive bps_opcode=op for exactly one cycle, then go to GUARD.
  - If bps_stall==1, hold with bps_opcode=0.
- GUARD: count GUARD cycles ignoring bps_stall, then go to WAIT.
- WAIT: when bps_stall==0, go to NEXT.
- NEXT (one cycle) computes the next op:
  - LOAD -> DOWN.
  - DOWN -> STORE_DOWN, or UP if stores are skipped this iteration.
  - STORE_DOWN -> UP.
  - UP -> STORE_UP, or iteration end if skipped.
  - STORE_UP -> iteration end.
  - Stores are skipped when store_last_only=1 and iter_count+1 < iterations.
  - Iteration end: iter_count++. If iter_count == iterations, or abort was seen, go to FIN; else set op=DOWN and go to ISSUE.
- Abort: sticky once asserted while busy, cleared at FIN. Only checked at iteration end or after LOAD, so bps is never left with an unstored half-iteration. Abort in IDLE is ignored.
- FIN: done=1 for one cycle, busy=0, go to IDLE. A start arriving in the FIN cycle is ignored.
- Opcode latency: from start to the LOAD pulse is 1 cycle when bps_stall==0.
- Opcode count per run:
  - Normal: 1 + 4N.
  - store_last_only: 1 + 2N + 2.
- iter_count saturates at the latched iterations value and holds after done until the next start.

Optional Feature:
- BPS_SEQ_TIMEOUT_EN: adds a TIMEOUT_W-bit counter.
  - Cleared on each entry to GUARD; increments in WAIT.
  - If it reaches all-ones: set error=1 (sticky until rst or next accepted start), force FSM to FIN, pulse done.
- Without the macro: no counter, error is tied 0, and WAIT has no exit other than bps_stall==0.

Decomposition:
- Shared package bps_pkg holds:
  - Opcode constants OP_IDLE..OP_STORE_UP (values 0..5).
  - The opcode width constant (3).
  - The FSM state encoding typedef, also reused by future multi-tile schedulers.
- One natural sub-module, bps_seq_wdog: the timeout counter, instantiated only under BPS_SEQ_TIMEOUT_EN.

Test Plan:
- iterations=1, store_last_only=0, bps model stalls 20 cycles per op -> opcodes 1,2,4,3,5 each pulsed once; done after the last stall clears; iter_count=1.
- iterations=3, store_last_only=1 -> sequence 1,2,3,2,3,2,4,3,5 (9 pulses); iter_count=3.
- iterations=0 -> no opcode pulses; busy high 1 cycle; done pulse; iter_count=0.
- iterations=5, abort asserted during the second DOWN -> iteration 2 completes fully (through STORE_UP); done; iter_count=2; no further DOWN.
- bps_stall already high at start, and stall rising 1 cycle after the pulse with GUARD=1 -> no opcode is issued while stall is high and no premature advance; rst mid-WAIT forces bps_opcode=0, busy=0 on the next edge.
- With BPS_SEQ_TIMEOUT_EN, TIMEOUT_W=4, stall held high -> error=1 and done pulse 15 cycles after entering WAIT; the next start clears error.

Source files
------------

// File: rtl/bps_pkg.sv
// Shared definitions for the bps opcode sequencer and future multi-tile
// schedulers: opcode encoding as seen by the bps tile and the sequencer
// FSM state encoding.
package bps_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_IDLE       = 3'd0;
  localparam logic [OP_W-1:0] OP_LOAD       = 3'd1;
  localparam logic [OP_W-1:0] OP_DOWN       = 3'd2;
  localparam logic [OP_W-1:0] OP_UP         = 3'd3;
  localparam logic [OP_W-1:0] OP_STORE_DOWN = 3'd4;
  localparam logic [OP_W-1:0] OP_STORE_UP   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GUARD,
    ST_WAIT,
    ST_NEXT,
    ST_FIN
  } bps_state_e;

endpackage

// File: rtl/bps_seq_if.sv
// Opcode bus between the sequencer (master) and one bps tile (slave).
interface bps_seq_if;
  import bps_pkg::*;

  logic [OP_W-1:0] bps_opcode;
  logic [63:0]     bps_addr_base;
  logic            bps_stall;

  modport master (output bps_opcode, output bps_addr_base, input bps_stall);
  modport slave  (input bps_opcode, input bps_addr_base, output bps_stall);
endinterface

// File: rtl/bps_seq_wdog.sv
// Watchdog for the WAIT state: counts cycles spent waiting on bps_stall and
// flags expiry on the cycle the count reaches all-ones.
module bps_seq_wdog #(
  parameter int TIMEOUT_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  // Next count: clear on GUARD entry, saturating increment while waiting
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = inc_i && (cnt_q == (CNT_MAX - 1'b1));

endmodule

// File: rtl/bps_seq.sv
// bps_seq: opcode sequencer for one bps tile. Issues LOAD, then N passes of
// DOWN / STORE_DOWN / UP / STORE_UP as one-cycle pulses, waiting for
// bps_stall to clear between opcodes.
// Optional feature: define BPS_SEQ_TIMEOUT_EN to add the WAIT watchdog that
// raises error and ends the run; without it error is tied low.
module bps_seq
  import bps_pkg::*;
#(
  parameter int ITER_W    = 16,
  parameter int GUARD     = 1,
  parameter int TIMEOUT_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] iterations,
  input  logic [63:0]       addr_base_in,
  input  logic              store_last_only,
  bps_seq_if.master         bps,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_count,
  output logic              error
);

  if (GUARD < 1 || GUARD > 3 || TIMEOUT_W < 2) begin : g_bad_param
    $error("bps_seq: GUARD must be 1..3 and TIMEOUT_W at least 2");
  end

  localparam logic [1:0] GUARD_LAST = 2'(GUARD - 1);

  bps_state_e        state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] iters_q, iters_d;
  logic [63:0]       addr_q, addr_d;
  logic              sll_q, sll_d;
  logic              abort_q, abort_d;
  logic [1:0]        gcnt_q, gcnt_d;
  logic [OP_W-1:0]   opcode_c;
  logic              iter_end;

  logic              busy_c;
  logic              abort_seen;
  logic [ITER_W:0]   iter_p1;
  logic              skip_store;
  logic              iter_last;
  logic [ITER_W-1:0] iter_sat;

  // Iteration bookkeeping shared by the NEXT-state decisions
  assign busy_c     = (state_q != ST_IDLE);
  assign abort_seen = abort_q | abort;
  assign iter_p1    = {1'b0, iter_q} + {{ITER_W{1'b0}}, 1'b1};
  assign skip_store = sll_q && (iter_p1 < {1'b0, iters_q});
  assign iter_last  = (iter_p1 >= {1'b0, iters_q});
  assign iter_sat   = (iter_q < iters_q) ? iter_p1[ITER_W-1:0] : iter_q;

`ifdef BPS_SEQ_TIMEOUT_EN
  logic wd_clr, wd_inc, wd_expire;
  logic err_q, err_d;

  bps_seq_wdog #(.TIMEOUT_W(TIMEOUT_W)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .inc_i    (wd_inc),
    .expire_o (wd_expire)
  );

  // Sticky watchdog flag, cleared by reset or a newly accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  // Next-state, opcode pulse and run bookkeeping
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    iter_d   = iter_q;
    iters_d  = iters_q;
    addr_d   = addr_q;
    sll_d    = sll_q;
    abort_d  = abort_q;
    gcnt_d   = gcnt_q;
    opcode_c = OP_IDLE;
    iter_end = 1'b0;
`ifdef BPS_SEQ_TIMEOUT_EN
    wd_clr   = 1'b0;
    wd_inc   = 1'b0;
    err_d    = err_q;
`endif

    if (busy_c && abort) begin
      abort_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          iters_d = iterations;
          addr_d  = addr_base_in;
          sll_d   = store_last_only;
          iter_d  = '0;
          abort_d = 1'b0;
`ifdef BPS_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          if (iterations == '0) begin
            state_d = ST_FIN;
          end else begin
            op_d    = OP_LOAD;
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        // The pulse is gated combinationally so it never overlaps a stall
        if (!bps.bps_stall) begin
          opcode_c = op_q;
          gcnt_d   = '0;
          state_d  = ST_GUARD;
`ifdef BPS_SEQ_TIMEOUT_EN
          wd_clr   = 1'b1;
`endif
        end
      end

      ST_GUARD: begin
        if (gcnt_q == GUARD_LAST) begin
          state_d = ST_WAIT;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end

      ST_WAIT: begin
        if (!bps.bps_stall) begin
          state_d = ST_NEXT;
        end
`ifdef BPS_SEQ_TIMEOUT_EN
        else begin
          wd_inc = 1'b1;
          if (wd_expire) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end
        end
`endif
      end

      ST_NEXT: begin
        state_d = ST_ISSUE;
        case (op_q)
          OP_LOAD: begin
            if (abort_seen) begin
              state_d = ST_FIN;
            end else begin
              op_d = OP_DOWN;
            end
          end
          OP_DOWN:       op_d = skip_store ? OP_UP : OP_STORE_DOWN;
          OP_STORE_DOWN: op_d = OP_UP;
          OP_UP: begin
            if (skip_store) begin
              iter_end = 1'b1;
            end else begin
              op_d = OP_STORE_UP;
            end
          end
          default:       iter_end = 1'b1;
        endcase
        if (iter_end) begin
          iter_d = iter_sat;
          if (iter_last || abort_seen) begin
            state_d = ST_FIN;
          end else begin
            op_d = OP_DOWN;
          end
        end
      end

      ST_FIN: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_IDLE;
      iter_q  <= '0;
      addr_q  <= '0;
      abort_q <= 1'b0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      iter_q  <= iter_d;
      addr_q  <= addr_d;
      abort_q <= abort_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Run parameters latched on start; only meaningful while busy
  always_ff @(posedge clk) begin
    iters_q <= iters_d;
    sll_q   <= sll_d;
  end

  assign bps.bps_opcode    = opcode_c;
  assign bps.bps_addr_base = addr_q;
  assign busy              = busy_c;
  assign done              = (state_q == ST_FIN);
  assign iter_count        = iter_q;

endmodule

// File: tb/tb_bps_seq.sv
// Testbench for bps_seq: a bps tile model raises stall the cycle after each
// pulse for a random or fixed number of cycles; an opcode list built from the
// sequencing rules is compared against the observed pulses.
`timescale 1ns/1ps
module tb_bps_seq;

  localparam int ITER_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [ITER_W-1:0] iterations;
  logic [63:0]       addr_in;
  logic              sll;
  logic              busy;
  logic              done;
  logic [ITER_W-1:0] iter_count;
  logic              error;

  bps_seq_if bif();

  bps_seq #(.ITER_W(ITER_W), .GUARD(1), .TIMEOUT_W(20)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .iterations      (iterations),
    .addr_base_in    (addr_in),
    .store_last_only (sll),
    .bps             (bif.master),
    .busy            (busy),
    .done            (done),
    .iter_count      (iter_count),
    .error           (error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int stall_left = 0;
  int stall_fix = -1;
  int abort_at = 0;
  int pulses = 0;
  int last_d = 0;
  int last_pulse_cyc = 0;
  int first_pulse_cyc = -1;
  int done_cnt = 0;
  int done_cyc = -1;
  int busy_cyc = 0;
  logic [63:0] cur_addr = '0;
  logic [2:0] obs_q[$];
  logic [2:0] exp_q[$];
  int exp_iter = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, want);
  endtask

  // One clock: drive stall just after the edge, sample everything mid-cycle
  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    bif.bps_stall = (stall_left > 0);
    if (stall_left > 0) stall_left--;
    @(negedge clk);
    cyc++;
    if (busy) busy_cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bif.bps_opcode != 3'd0) begin
      pulses++;
      obs_q.push_back(bif.bps_opcode);
      if (pulses == 1) first_pulse_cyc = cyc;
      check("no_pulse_while_stall", 64'(bif.bps_stall), 64'd0);
      check("addr_hold", bif.bps_addr_base, cur_addr);
      last_pulse_cyc = cyc;
      last_d = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 5));
      stall_left = last_d;
      if (pulses == abort_at) abort = 1'b1;
    end
  endtask

  // Expected opcode list: LOAD, then per pass DOWN [STORE_DOWN] UP [STORE_UP];
  // an abort raised at pulse ab stops at the first LOAD/pass boundary >= ab.
  function automatic void build_expected(input int n, input bit s, input int ab);
    bit skip;
    exp_q.delete();
    exp_iter = 0;
    if (n == 0) return;
    exp_q.push_back(3'd1);
    if (ab > 0 && exp_q.size() >= ab) return;
    for (int i = 0; i < n; i++) begin
      skip = s && (i + 1 < n);
      exp_q.push_back(3'd2);
      if (!skip) exp_q.push_back(3'd4);
      exp_q.push_back(3'd3);
      if (!skip) exp_q.push_back(3'd5);
      exp_iter = i + 1;
      if (ab > 0 && exp_q.size() >= ab) return;
    end
  endfunction

  task automatic clear_track();
    obs_q.delete();
    pulses = 0;
    done_cnt = 0;
    done_cyc = -1;
    busy_cyc = 0;
    first_pulse_cyc = -1;
  endtask

  task automatic do_run(input int n, input bit s, input int pre, input int fix, input int ab);
    int start_cyc;
    clear_track();
    abort_at = ab;
    stall_fix = fix;
    cur_addr = {$urandom, $urandom};
    iterations = ITER_W'(n);
    sll = s;
    addr_in = cur_addr;
    start = 1'b1;
    stall_left = pre;
    start_cyc = cyc;
    tick();
    for (int k = 0; k < 3000 && done_cnt == 0; k++) tick();
    check("done_seen", 64'(done_cnt > 0), 64'd1);
    build_expected(n, s, ab);
    check("pulse_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("opcode[%0d]", i), 64'(obs_q[i]), 64'(exp_q[i]));
    check("iter_count", 64'(iter_count), 64'(exp_iter));
    check("error_low", 64'(error), 64'd0);
    check("busy_cycles", 64'(busy_cyc), 64'(done_cyc - start_cyc));
    if (exp_q.size() > 0) begin
      check("load_latency", 64'(first_pulse_cyc - start_cyc), 64'(pre + 1));
      check("done_gap", 64'(done_cyc - last_pulse_cyc), 64'(((last_d < 1) ? 1 : last_d) + 3));
    end else begin
      check("done_gap_empty", 64'(done_cyc - start_cyc), 64'd1);
    end
    tick();
    tick();
    check("done_single", 64'(done_cnt), 64'd1);
    check("busy_after", 64'(busy), 64'd0);
    check("iter_hold", 64'(iter_count), 64'(exp_iter));
    check("no_extra_pulse", 64'(obs_q.size()), 64'(exp_q.size()));
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    iterations = '0;
    addr_in = '0;
    sll = 1'b0;
    bif.bps_stall = 1'b0;
    tick();
    tick();
    check("rst_opcode", 64'(bif.bps_opcode), 64'd0);
    check("rst_addr", bif.bps_addr_base, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_iter", 64'(iter_count), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    rst = 1'b0;
    tick();

    // Directed scenarios
    do_run(1, 1'b0, 0, 20, 0);
    do_run(3, 1'b1, 0, -1, 0);
    do_run(0, 1'b0, 0, -1, 0);
    do_run(5, 1'b0, 0, -1, 6);
    do_run(2, 1'b0, 4, -1, 0);
    do_run(3, 1'b0, 0, 1, 1);

    // Abort while idle must not affect the next run
    abort = 1'b1;
    tick();
    do_run(2, 1'b0, 0, -1, 0);

    // Start presented during the FIN cycle is ignored
    clear_track();
    stall_fix = -1;
    abort_at = 0;
    iterations = '0;
    start = 1'b1;
    tick();
    check("fin_done", 64'(done), 64'd1);
    iterations = ITER_W'(2);
    start = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) tick();
    check("fin_start_ignored", 64'(pulses), 64'd0);
    check("fin_start_busy", 64'(busy), 64'd0);

    // Reset in the middle of WAIT
    clear_track();
    stall_fix = 20;
    cur_addr = {$urandom, $urandom};
    addr_in = cur_addr;
    iterations = ITER_W'(2);
    sll = 1'b0;
    start = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) tick();
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    stall_left = 0;
    tick();
    rst = 1'b0;
    check("midrst_opcode", 64'(bif.bps_opcode), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_iter", 64'(iter_count), 64'd0);
    for (int k = 0; k < 6; k++) tick();
    check("midrst_no_pulse", 64'(pulses), 64'd1);
    check("midrst_idle", 64'(busy), 64'd0);

    // Randomized runs
    for (int r = 0; r < 14; r++) begin
      int n;
      int ab;
      n = int'($urandom_range(0, 4));
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 18)) : 0;
      do_run(n, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1, ab);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
